// File: rtl/mult_taint_pkg.sv
// rtl/mult_taint_pkg.sv - shared encodings for the taint-tracked multiplier
// Purpose: state encoding, control-bundle bit ordering and counter-width helper
//   shared by the controller, the datapath and top-level tests.
// Ports: none (package).
package mult_taint_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_INIT  = S_INIT,
    ST_CHECK = S_CHECK,
    ST_ADD   = S_ADD,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

  // Bit positions of the datapath controls inside a control bundle.
  localparam int CTL_MDLD    = 0;
  localparam int CTL_MRLD    = 1;
  localparam int CTL_RSCLEAR = 2;
  localparam int CTL_RSLOAD  = 3;
  localparam int CTL_RSSHR   = 4;
  localparam int CTL_N       = 5;

  typedef logic [CTL_N-1:0] ctl_t;

  // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_controller_taint_track_if.sv
// rtl/mult_controller_taint_track_if.sv - controller <-> datapath/start bus
// Purpose: groups start, multiplier readback and control/taint outputs.
// Macro: MULT_CTRL_ABORT_EN adds abort/abort_t.
// Modports: master = controller (drives controls), slave = datapath/stimulus side.
interface mult_controller_taint_track_if #(
  parameter int WIDTH = 4
);
  import mult_taint_pkg::*;

  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] multiplierReg;
  logic [WIDTH-1:0] multiplierReg_t;
  logic             mdld, mrld, rsclear, rsload, rsshr;
  logic             mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t;
  logic             busy;
  logic             done;
  logic             done_t;
`ifdef MULT_CTRL_ABORT_EN
  logic             abort;
  logic             abort_t;

  modport master (
    input  start, start_t, multiplierReg, multiplierReg_t, abort, abort_t,
    output mdld, mrld, rsclear, rsload, rsshr,
    output mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
    output busy, done, done_t
  );

  modport slave (
    output start, start_t, multiplierReg, multiplierReg_t, abort, abort_t,
    input  mdld, mrld, rsclear, rsload, rsshr,
    input  mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
    input  busy, done, done_t
  );
`else
  modport master (
    input  start, start_t, multiplierReg, multiplierReg_t,
    output mdld, mrld, rsclear, rsload, rsshr,
    output mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
    output busy, done, done_t
  );

  modport slave (
    output start, start_t, multiplierReg, multiplierReg_t,
    input  mdld, mrld, rsclear, rsload, rsshr,
    input  mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t,
    input  busy, done, done_t
  );
`endif

endinterface

// File: rtl/mult_bit_counter.sv
// rtl/mult_bit_counter.sv - multiplier bit-index counter
// Purpose: CNT_W-bit index with synchronous clear/increment and last-bit flag.
// Ports: clk, rst_n (async active-low), clear, inc, cnt (index), last (cnt == WIDTH-1).
module mult_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_controller_taint_track.sv
// rtl/mult_controller_taint_track.sv - taint-tracked shift-add multiplier controller
// Purpose: LSB-first shift-add control FSM; taint from start and inspected
//   multiplier bits is carried in state_t and copied onto every asserted control.
// Ports: clk, rst_n (async active-low), bus (master modport: start/start_t,
//   multiplierReg/_t in; mdld/mrld/rsclear/rsload/rsshr + _t, busy, done, done_t out).
// Macro: MULT_CTRL_ABORT_EN adds bus.abort/abort_t (return to IDLE, no done).
module mult_controller_taint_track
  import mult_taint_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mult_controller_taint_track_if.master bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           state, state_n;
  logic             state_t, state_t_n;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic [CNT_W-1:0] cnt;
  ctl_t             ctl;

  mult_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      state_t <= 1'b0;
    end else begin
      state   <= state_n;
      state_t <= state_t_n;
    end
  end

  always_comb begin
    state_n   = state;
    state_t_n = state_t;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      // The IDLE decision depends on start whichever way it goes, so its taint
      // replaces the previous operation's taint unconditionally.
      ST_IDLE: begin
        state_t_n = bus.start_t;
        if (bus.start) state_n = ST_INIT;
      end
      ST_INIT: begin
        cnt_clr = 1'b1;
        state_n = ST_CHECK;
      end
      ST_CHECK: begin
        state_t_n = state_t | bus.multiplierReg_t[cnt];
        state_n   = bus.multiplierReg[cnt] ? ST_ADD : ST_SHIFT;
      end
      ST_ADD: state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_last) begin
          cnt_clr = 1'b1;
          state_n = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_n = ST_CHECK;
        end
      end
      ST_DONE: begin
        cnt_clr = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_t_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase
`ifdef MULT_CTRL_ABORT_EN
    // Abort wins over every other transition, including SHIFT->DONE.
    if (bus.abort && (state != ST_IDLE)) begin
      state_n   = ST_IDLE;
      state_t_n = state_t | bus.abort_t;
      cnt_clr   = 1'b1;
      cnt_inc   = 1'b0;
    end
`endif
  end

  // Moore decode: controls depend on state only; taints gate with state_t.
  always_comb begin
    ctl = '0;
    case (state)
      ST_INIT: begin
        ctl[CTL_MDLD]    = 1'b1;
        ctl[CTL_MRLD]    = 1'b1;
        ctl[CTL_RSCLEAR] = 1'b1;
      end
      ST_ADD:   ctl[CTL_RSLOAD] = 1'b1;
      ST_SHIFT: ctl[CTL_RSSHR]  = 1'b1;
      default:  ctl = '0;
    endcase
    bus.mdld      = ctl[CTL_MDLD];
    bus.mrld      = ctl[CTL_MRLD];
    bus.rsclear   = ctl[CTL_RSCLEAR];
    bus.rsload    = ctl[CTL_RSLOAD];
    bus.rsshr     = ctl[CTL_RSSHR];
    bus.mdld_t    = ctl[CTL_MDLD]    & state_t;
    bus.mrld_t    = ctl[CTL_MRLD]    & state_t;
    bus.rsclear_t = ctl[CTL_RSCLEAR] & state_t;
    bus.rsload_t  = ctl[CTL_RSLOAD]  & state_t;
    bus.rsshr_t   = ctl[CTL_RSSHR]   & state_t;
    bus.busy      = (state != ST_IDLE);
    bus.done      = (state == ST_DONE);
    bus.done_t    = (state == ST_DONE) & state_t;
  end

endmodule

// File: tb/tb_mult_controller_taint_track.sv
// tb/tb_mult_controller_taint_track.sv - self-checking bench for mult_controller_taint_track
module tb_mult_controller_taint_track;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_controller_taint_track_if #(.WIDTH(W)) bus_if ();

  mult_controller_taint_track #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, done, done_t, mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t}
  function automatic logic [12:0] obs();
    return {bus_if.busy, bus_if.done, bus_if.done_t,
            bus_if.mdld, bus_if.mdld_t, bus_if.mrld, bus_if.mrld_t,
            bus_if.rsclear, bus_if.rsclear_t, bus_if.rsload, bus_if.rsload_t,
            bus_if.rsshr, bus_if.rsshr_t};
  endfunction

  function automatic logic [12:0] ev(input logic busy, dn, md, mr, rc, rl, rs, t);
    return {busy, dn, dn & t, md, md & t, mr, mr & t, rc, rc & t, rl, rl & t, rs, rs & t};
  endfunction

  // Reference: per-cycle output trace of one multiply, from cycle 1 (INIT) to DONE.
  function automatic void build(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st);
    logic t;
    exp_q.delete();
    t = st;
    exp_q.push_back(ev(1, 0, 1, 1, 1, 0, 0, t));
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, t));
      t = t | mt[i];
      if (m[i]) exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 0, t));
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 1, t));
    end
    exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, t));
  endfunction

  task automatic run(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st,
                     input bit noise, input string tag);
    int rl_cnt, rs_cnt, done_cyc;
    build(m, mt, st);
    @(negedge clk);
    bus_if.multiplierReg   = m;
    bus_if.multiplierReg_t = mt;
    bus_if.start           = 1'b1;
    bus_if.start_t         = st;
    @(posedge clk);
    rl_cnt = 0; rs_cnt = 0; done_cyc = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, k + 1), obs(), exp_q[k]);
      rl_cnt += bus_if.rsload;
      rs_cnt += bus_if.rsshr;
      if (bus_if.done && done_cyc == 0) done_cyc = k + 1;
      if (noise && (k + 1 < exp_q.size())) begin
        bus_if.start   = 1'($urandom);
        bus_if.start_t = 1'($urandom);
      end else begin
        bus_if.start   = 1'b0;
        bus_if.start_t = 1'b0;
      end
    end
    check({tag, " latency"}, done_cyc, 2 + 2 * W + $countones(m));
    check({tag, " rsload_cnt"}, rl_cnt, $countones(m));
    check({tag, " rsshr_cnt"}, rs_cnt, W);
    @(negedge clk);
    check({tag, " idle"}, obs(), 13'd0);
  endtask

  initial begin
    bus_if.start           = 1'b0;
    bus_if.start_t         = 1'b0;
    bus_if.multiplierReg   = '0;
    bus_if.multiplierReg_t = '0;
`ifdef MULT_CTRL_ABORT_EN
    bus_if.abort           = 1'b0;
    bus_if.abort_t         = 1'b0;
`endif
    #1;
    check("reset outputs", obs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset idle", obs(), 13'd0);

    run(4'b1011, 4'b0000, 1'b0, 1'b0, "t2");
    run(4'b0000, 4'b0000, 1'b0, 1'b0, "t3 zero");
    run(4'b1111, 4'b0000, 1'b0, 1'b0, "t3 ones");
    run(4'b0101, 4'b0100, 1'b0, 1'b0, "t4 taint");
    run(4'b0101, 4'b0000, 1'b0, 1'b0, "t4 clear");
    run(4'b1011, 4'b0000, 1'b1, 1'b1, "t5 start_t");

    // Reset in the ADD state of bit 0 (cycle 3).
    @(negedge clk);
    bus_if.multiplierReg = 4'b1011;
    bus_if.multiplierReg_t = '0;
    bus_if.start = 1'b1;
    bus_if.start_t = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("t1 pre-reset add", obs(), ev(1, 0, 0, 0, 0, 1, 0, 0));
    rst_n = 1'b0;
    #1;
    check("t1 async clear", obs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t1 after release %0d", k), obs(), 13'd0);
    end

`ifdef MULT_CTRL_ABORT_EN
    // Abort in CHECK of bit 2 for multiplier 0101 (cycle 7).
    @(negedge clk);
    bus_if.multiplierReg = 4'b0101;
    bus_if.multiplierReg_t = '0;
    bus_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (6) @(negedge clk);
    check("t6 check bit2", obs(), ev(1, 0, 0, 0, 0, 0, 0, 0));
    bus_if.abort = 1'b1;
    bus_if.abort_t = 1'b1;
    @(negedge clk);
    check("t6 aborted", obs(), 13'd0);
    bus_if.abort = 1'b0;
    bus_if.abort_t = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("t6 no done %0d", k), obs(), 13'd0);
    end
`endif

    for (int r = 0; r < 24; r++) begin
      logic [W-1:0] m, mt;
      logic st;
      bit nz;
      m  = W'($urandom);
      mt = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      st = ($urandom_range(0, 3) == 0);
      nz = 1'($urandom);
      run(m, mt, st, nz, $sformatf("rand%0d m=%0h mt=%0h st=%0b", r, m, mt, st));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
